turn_sensor: RTL

Conditions the hall-effect turn sensor of the rotating LED head and feeds the `turn_tick` input of the HPS register block. Synchronises and debounces the raw sensor, applies the HPS override for the tick, measures the rotation period in `clk` cycles and flags a stalled rotor. Its outputs drive the column timing logic and the HPS interrupt path.

---
 rtl/litspin_pkg.sv | 16 +
 rtl/turn_debounce.sv | 56 +++++
 rtl/turn_sensor.sv | 112 +++++++++++
 3 files changed

// File: rtl/litspin_pkg.sv
// litspin_pkg: definitions shared across the LED-head rotation logic.
//   turn_state_t : rotation-measurement FSM state of turn_sensor.
//   cnt_width()  : width needed to hold a count in the range 0..n (minimum 1).
package litspin_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        RUN        = 2'd2
    } turn_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/turn_debounce.sv
// turn_debounce: synchronises the raw active-low hall sensor into clk and
// filters it, so that the level only follows the sensor after it has held a
// new value for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk    in  system clock
//   rst_in in  synchronous active-high reset
//   raw_n  in  asynchronous hall sensor, low while the magnet is present
//   level  out filtered level, high while the magnet is present
module turn_debounce
    import litspin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_in,
    input  logic raw_n,
    output logic level
);

    localparam int unsigned   CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          raw;
    logic          filt;
    logic [CW-1:0] cnt;

    // Synchroniser resets to "no magnet", so the sensor reads inactive.
    assign raw = ~sync2;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            filt  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            // Any return to the current filtered level restarts the count,
            // so only an unbroken run of the new level gets through.
            if (raw == filt) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                filt <= raw;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign level = filt;

endmodule

// File: rtl/turn_sensor.sv
// turn_sensor: conditions the hall turn sensor of the rotating LED head.
// Debounces the sensor, selects the HPS tick under override, measures the
// rising-to-rising tick period in clk cycles and flags a stalled rotor.
// Ports:
//   clk           in  system clock
//   rst_in        in  synchronous active-high reset
//   hall_n        in  raw hall sensor, asynchronous, low while magnet present
//   hps_override  in  selects hps_turn_tick as tick source
//   hps_turn_tick in  HPS tick level, synchronous to clk
//   turn_tick     out registered tick level
//   turn_period   out last measured rise-to-rise distance in cycles
//   period_valid  out turn_period holds a valid measurement
//   period_strobe out one-cycle pulse when turn_period updates
//   stalled       out no rotation detected
module turn_sensor
    import litspin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned PERIOD_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    hall_n,
    input  logic                    hps_override,
    input  logic                    hps_turn_tick,
    output logic                    turn_tick,
    output logic [PERIOD_WIDTH-1:0] turn_period,
    output logic                    period_valid,
    output logic                    period_strobe,
    output logic                    stalled
);

    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = PERIOD_WIDTH'(TIMEOUT_CYCLES - 1);

    logic                    level;
    logic                    prev;
    logic                    rise;
    logic                    timeout;
    logic [PERIOD_WIDTH-1:0] cnt;
    turn_state_t             state;

    turn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_in(rst_in),
        .raw_n (hall_n),
        .level (level)
    );

    assign rise    = turn_tick & ~prev;
    assign timeout = (cnt == CNT_MAX);

    // Tick source select, edge history and the saturating period counter.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            turn_tick <= 1'b0;
            prev      <= 1'b0;
            cnt       <= '0;
        end else begin
            turn_tick <= hps_override ? hps_turn_tick : level;
            prev      <= turn_tick;
            if (rise) begin
                cnt <= '0;
            end else if (!timeout) begin
                cnt <= cnt + PERIOD_WIDTH'(1);
            end
        end
    end

    // cnt holds cycles since the last rise minus one, hence the +1 on capture.
    // A rise in the timeout cycle is checked first so the measurement wins.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state         <= WAIT_FIRST;
            turn_period   <= '0;
            period_valid  <= 1'b0;
            period_strobe <= 1'b0;
            stalled       <= 1'b1;
        end else begin
            period_strobe <= 1'b0;
            unique case (state)
                WAIT_FIRST: begin
                    stalled      <= 1'b1;
                    period_valid <= 1'b0;
                    if (rise) begin
                        stalled <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                MEASURE, RUN: begin
                    if (rise) begin
                        turn_period   <= cnt + PERIOD_WIDTH'(1);
                        period_strobe <= 1'b1;
                        period_valid  <= 1'b1;
                        stalled       <= 1'b0;
                        state         <= RUN;
                    end else if (timeout) begin
                        period_valid <= 1'b0;
                        stalled      <= 1'b1;
                        state        <= WAIT_FIRST;
                    end
                end
                default: begin
                    state <= WAIT_FIRST;
                end
            endcase
        end
    end

endmodule
